device_result_collector: RTL
============================

Name: device_result_collector

Overview:
- Downstream consumer of the device test-sequencer outputs `pass`, `fail` and `Q[7:0]`.
- Detects each new pass or fail result on a rising edge, tags it with the `Q` byte sampled in the same cycle, and buffers it in a first-word-fall-through FIFO that a host drains over valid/ready.
- Keeps saturating pass and fail counters plus sticky overflow and conflict flags for status readout.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- CNT_W, 16: width of pass_cnt and fail_cnt.
- TS_W, 16: timestamp width; used only when RESULT_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pass  in  1  pass level from the device; may stay high for many cycles.
- fail  in  1  fail level from the device; may stay high for many cycles.
- q  in  8  device Q byte, sampled on an event.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- rec_valid  out  1  FIFO head is valid.
- rec_ready  in  1  host accepts the head.
- rec_code  out  2  head code: 01 pass, 10 fail, 11 conflict.
- rec_data  out  8  head q value.
- rec_ts  out  TS_W  head timestamp; port exists only with RESULT_TIMESTAMP_EN.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- pass_cnt  out  CNT_W  saturating count of pass events.
- fail_cnt  out  CNT_W  saturating count of fail events.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- conflict  out  1  sticky: pass and fail rose in the same cycle.

Behaviour:
- Reset (rst=1, asynchronous), all zero: pass_d, fail_d, FIFO pointers, level, rec_valid, pass_cnt, fail_cnt, overflow, conflict, timestamp counter.
- Edge detect:
  - pass_d and fail_d register pass and fail every cycle, including while clear=1.
  - pass_ev = pass & ~pass_d; fail_ev = fail & ~fail_d.
  - A level held high produces exactly one event.
- Record on event:
  - code = {fail_ev, pass_ev}; data = q from the same cycle.
  - Push at that cycle's edge. rec_valid and head fields are visible the next cycle (1-cycle latency into an empty FIFO).
- Pop: occurs when rec_valid & rec_ready at the edge. rec_ready while rec_valid=0 is ignored.
- Head stability: rec_code, rec_data and rec_ts stay stable while rec_valid=1 and rec_ready=0.
- Full FIFO:
  - A push with no pop that cycle is dropped and overflow is set. Counters still increment.
  - Push and pop in the same cycle while full: both take effect, level stays DEPTH, nothing dropped.
- Empty FIFO, push only: level goes 0 to 1, rec_valid rises next cycle.
- Pointers: wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit; `level` equals write pointer minus read pointer.
- Counters:
  - pass_ev increments pass_cnt; fail_ev increments fail_cnt.
  - Each counter saturates at 2^CNT_W-1.
  - Conflict (both events in one cycle): code 11, both counters increment, conflict set.
- Clear (synchronous, highest priority):
  - Next cycle: level=0, rec_valid=0, counters and flags are 0.
  - Same-cycle events are discarded.
  - Pop is ignored that cycle.
  - Timestamp counter is unaffected.
- Reset mid-operation: all state is lost immediately and outputs go to reset values.
  - After rst deasserts, pass_d=0, so a pass still held high produces one event on the first clock.
- Sticky flags clear only on rst or clear.

Optional Feature:
- RESULT_TIMESTAMP_EN defined:
  - A free-running TS_W-bit cycle counter wraps at 2^TS_W, resets to 0, and is not cleared by `clear`.
  - Each record stores the counter value from its event cycle.
  - rec_ts presents the head timestamp; FIFO width is 10+TS_W.
- Not defined: no counter, no rec_ts port, FIFO width is 10.

Test Plan:
- Single pass: after reset, q=8'hA5, pass held high for 5 cycles, rec_ready=0.
  - Required: exactly one record, code 01, data A5, rec_valid high one cycle after the rise, level=1, pass_cnt=1.
- Fill and overflow (DEPTH=8): 9 fail pulses, q=0..8, rec_ready=0.
  - Required: level=8, overflow=1, fail_cnt=9.
  - Draining returns data 0..7 in order, then rec_valid=0.
- Full plus simultaneous push/pop: with FIFO full, a pass event in the same cycle as rec_ready=1.
  - Required: head pops, new record enters, level stays 8, overflow stays 0.
- Conflict: pass and fail rise in the same cycle with q=8'h3C.
  - Required: record code 11, data 3C, pass_cnt and fail_cnt each +1, conflict=1.
- Clear vs event: clear=1 in the same cycle as a pass rise, with 3 records queued.
  - Required: next cycle level=0, rec_valid=0, counters 0, no record for that pass.
  - pass held high afterwards produces no new event.
- Saturation and reset (CNT_W=4): 17 pass events.
  - Required: pass_cnt=15.
  - Asserting rst mid-burst zeroes all outputs asynchronously, before the next clock edge.

Source files
------------

// File: rtl/device_result_collector.sv
// ---------------------------------------------------------------------------
// device_result_collector
//
// Watches the pass/fail levels coming out of the device test sequencer.
// Every rising edge of either level is one result event. The event is tagged
// with the q byte from the same cycle and pushed into a first-word-fall-through
// FIFO that a host drains over a valid/ready port. Saturating pass/fail
// counters and sticky overflow/conflict flags give a status summary.
//
// Optional build macro: RESULT_TIMESTAMP_EN
//   When defined, a free-running TS_W-bit cycle counter is stored with every
//   record and the head timestamp is presented on rec_ts. When undefined the
//   counter and the rec_ts port do not exist.
//
// Handshake: the head record transfers on a rising clk edge where
//   rec_valid & rec_ready are both 1. rec_valid never depends on rec_ready,
//   and the head fields hold steady while rec_valid=1 and rec_ready=0.
//   rec_ready while rec_valid=0 has no effect.
//
// Ports
//   clk        clock, everything on its rising edge
//   rst        asynchronous active-high reset
//   pass/fail  result levels from the device (may be held high)
//   q          device Q byte, captured with each event
//   clear      synchronous flush of FIFO, counters and flags (highest priority)
//   rec_valid  FIFO head is valid
//   rec_ready  host accepts the head
//   rec_code   head code: 01 pass, 10 fail, 11 conflict (0 when empty)
//   rec_data   head q value (0 when empty)
//   rec_ts     head timestamp (RESULT_TIMESTAMP_EN only)
//   level      FIFO occupancy, 0..DEPTH
//   pass_cnt   saturating count of pass events
//   fail_cnt   saturating count of fail events
//   overflow   sticky: an event was dropped because the FIFO was full
//   conflict   sticky: pass and fail rose in the same cycle
// ---------------------------------------------------------------------------
module device_result_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pass,
  input  logic                     fail,
  input  logic [7:0]               q,
  input  logic                     clear,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [1:0]               rec_code,
  output logic [7:0]               rec_data,
`ifdef RESULT_TIMESTAMP_EN
  output logic [TS_W-1:0]          rec_ts,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     overflow,
  output logic                     conflict
);

  localparam int AW = $clog2(DEPTH);
`ifdef RESULT_TIMESTAMP_EN
  localparam int EW = 10 + TS_W;
`else
  localparam int EW = 10;
`endif

  // Elaboration-time guard on the parameter set.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || TS_W < 1) begin : g_param_err
    $error("device_result_collector: illegal parameter set");
  end

  localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // -------------------------------------------------------------------------
  // Edge detection. The delayed copies follow the inputs every cycle, even
  // while clear is high, so a level held across a clear never re-triggers.
  // -------------------------------------------------------------------------
  logic pass_dly_q, pass_dly_d;
  logic fail_dly_q, fail_dly_d;
  logic pass_ev, fail_ev, any_ev;

  assign pass_dly_d = pass;
  assign fail_dly_d = fail;
  assign pass_ev    = pass & ~pass_dly_q;
  assign fail_ev    = fail & ~fail_dly_q;
  assign any_ev     = pass_ev | fail_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_dly_q <= 1'b0;
      fail_dly_q <= 1'b0;
    end else begin
      pass_dly_q <= pass_dly_d;
      fail_dly_q <= fail_dly_d;
    end
  end

  // -------------------------------------------------------------------------
  // Optional free-running timestamp; deliberately untouched by clear.
  // -------------------------------------------------------------------------
`ifdef RESULT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  // -------------------------------------------------------------------------
  // FIFO pointers carry one extra bit so that full and empty are distinct
  // and the occupancy is simply the pointer difference.
  // -------------------------------------------------------------------------
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == FULL_LEVEL);
  assign rec_valid = (level != '0);

  // Clear wins over everything: no pop, no push that cycle.
  assign do_pop  = rec_valid & rec_ready & ~clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = any_ev & ~clear & (~full | do_pop);
  assign drop    = any_ev & ~clear & full & ~do_pop;

`ifdef RESULT_TIMESTAMP_EN
  assign wr_entry = {ts_q, q, fail_ev, pass_ev};
`else
  assign wr_entry = {q, fail_ev, pass_ev};
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // Head fields are forced to zero when empty so stale storage never shows
  // and the outputs read as zero straight out of reset.
  assign head_entry = rec_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign rec_code   = head_entry[1:0];
  assign rec_data   = head_entry[9:2];
`ifdef RESULT_TIMESTAMP_EN
  assign rec_ts     = head_entry[EW-1:10];
`endif

  // -------------------------------------------------------------------------
  // Status: saturating counters and sticky flags. Counters follow every
  // event, including ones dropped on overflow; only clear discards events.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             overflow_q, overflow_d;
  logic             conflict_q, conflict_d;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    overflow_d = overflow_q;
    conflict_d = conflict_q;
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      overflow_d = 1'b0;
      conflict_d = 1'b0;
    end else begin
      if (pass_ev && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_ev && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      if (drop)               overflow_d = 1'b1;
      if (pass_ev && fail_ev) conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      overflow_q <= overflow_d;
      conflict_q <= conflict_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign overflow = overflow_q;
  assign conflict = conflict_q;

endmodule
